// File: rtl/dual_port_ram_be_if.sv
// dual_port_ram_be_if: bus bundle for the byte-enabled true dual-port RAM.
//   master : drives clr, per-port write enables/address/write data; sees busy and read data
//   slave  : the RAM side of the same signals
// Clock and reset are plain ports on the RAM, not part of this bundle.
interface dual_port_ram_be_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BYTE_WIDTH = 8
);
  localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

  logic                  clr;
  logic                  busy;
  logic [NB-1:0]         we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic [NB-1:0]         we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic [DATA_WIDTH-1:0] dout_b;

  modport master (
    output clr, we_a, addr_a, din_a, we_b, addr_b, din_b,
    input  busy, dout_a, dout_b
  );

  modport slave (
    input  clr, we_a, addr_a, din_a, we_b, addr_b, din_b,
    output busy, dout_a, dout_b
  );
endinterface

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: true dual-port synchronous RAM with per-byte write enables on both ports,
// selectable read-during-write result, optional second output register, and a clear
// sequencer that fills the whole array with CLEAR_VALUE after reset or on a clr pulse.
// Ports:
//   clk_i   : clock, all state on the rising edge
//   rst_i   : asynchronous active-high reset (array contents are not reset)
//   bus     : slave modport of dual_port_ram_be_if
//             clr (request clear), busy (sequencer owns array),
//             we_x/addr_x/din_x/dout_x for ports A and B
module dual_port_ram_be #(
  parameter int unsigned           ADDR_WIDTH     = 6,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           BYTE_WIDTH     = 8,
  parameter int unsigned           RDW_MODE       = 0,
  parameter int unsigned           OUT_REG        = 0,
  parameter int unsigned           CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input logic                clk_i,
  input logic                rst_i,
  dual_port_ram_be_if.slave  bus
);

  localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $error("dual_port_ram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  // Clear sequencer states
  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StClear = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  // One-shot request that fires on the first edge after reset release
  logic                  start_q;
  logic                  busy;

  logic [NB-1:0]         we_a_eff, we_b_eff;
  logic                  same_addr;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic [DATA_WIDTH-1:0] dout1_a_q, dout1_b_q;

  assign busy     = (state_q == StClear);
  assign bus.busy = busy;

  // User writes are dropped while the sequencer owns the array
  assign we_a_eff  = busy ? '0 : bus.we_a;
  assign we_b_eff  = busy ? '0 : bus.we_b;
  assign same_addr = (bus.addr_a == bus.addr_b);

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_q || bus.clr) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        // clr is ignored here; a running clear is never restarted
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      start_q <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage. Port B lanes are written first so that port A's assignment to the
  // same address and lane lands last and wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (busy) begin
      mem_q[cnt_q] <= CLEAR_VALUE;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (we_b_eff[i]) begin
          mem_q[bus.addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (we_a_eff[i]) begin
          mem_q[bus.addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path. In write-first mode the stored word is byte-merged with this
  // cycle's writes from both ports, applying B before A so A wins on overlap.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_a = mem_q[bus.addr_a];
    rd_b = mem_q[bus.addr_b];
    if (RDW_MODE != 0) begin
      for (int i = 0; i < NB; i++) begin
        if (we_b_eff[i] && same_addr) begin
          rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (we_a_eff[i]) begin
          rd_a[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (we_b_eff[i]) begin
          rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (we_a_eff[i] && same_addr) begin
          rd_b[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    if (busy) begin
      rd_a = '0;
      rd_b = '0;
    end
  end

  // First output stage; keeps advancing during a clear, carrying zeros
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dout1_a_q <= '0;
      dout1_b_q <= '0;
    end else begin
      dout1_a_q <= rd_a;
      dout1_b_q <= rd_b;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout2_a_q, dout2_b_q;

    // Forced to zero while busy so a read captured just before a clear is not shown
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        dout2_a_q <= '0;
        dout2_b_q <= '0;
      end else begin
        dout2_a_q <= busy ? '0 : dout1_a_q;
        dout2_b_q <= busy ? '0 : dout1_b_q;
      end
    end

    assign bus.dout_a = dout2_a_q;
    assign bus.dout_b = dout2_b_q;
  end else begin : g_no_out_reg
    assign bus.dout_a = dout1_a_q;
    assign bus.dout_b = dout1_b_q;
  end

endmodule

// File: doc/dual_port_ram_be.md
# dual_port_ram_be

Parametrised true dual-port synchronous block RAM with per-byte write enables on both ports, selectable read-during-write behaviour, an optional output register stage, and a built-in clear sequencer that fills the array with a constant after reset or on request. General-purpose storage for the NES core (PPU palette/OAM, APU buffers, debug capture). Both ports share one clock domain.

## Interface
- ADDR_WIDTH, 6, address bits per port; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 8, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH lanes
- RDW_MODE, 0, read-during-write result: 0 = old data (read-first), 1 = new data (write-first)
- OUT_REG, 0, 1 adds a second output register stage (read latency 2)
- CLEAR_ON_RESET, 1, 1 = start the clear sequence when reset deasserts
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written to every location during clear

- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  one-cycle pulse requests a full-array clear
- busy  out  1  high while the clear sequencer owns the array
- we_a  in  NB  port A byte write enables
- addr_a  in  ADDR_WIDTH  port A address
- din_a  in  DATA_WIDTH  port A write data
- dout_a  out  DATA_WIDTH  port A read data
- we_b  in  NB  port B byte write enables
- addr_b  in  ADDR_WIDTH  port B address
- din_b  in  DATA_WIDTH  port B write data
- dout_b  out  DATA_WIDTH  port B read data

## Operation
- Each port reads addr every cycle; bytes with we set are written from the matching din lane; other bytes keep their value.
- RDW_MODE=0: dout returns the word as it was before this cycle's writes (both ports). RDW_MODE=1: dout returns the word after this cycle's writes, byte-merged, including writes from the other port.
- Same-address writes on both ports in one cycle: per byte, port A wins where both enable that lane; port B lanes apply where only B enables.
- Clear FSM states: IDLE, CLEAR. IDLE -> CLEAR on clr=1, or on first cycle after rst deasserts when CLEAR_ON_RESET=1. In CLEAR, counter starts at 0, writes CLEAR_VALUE to address counter each cycle, increments; after writing address 2**ADDR_WIDTH-1 -> IDLE.
- While busy: we_a/we_b ignored, dout_a/dout_b forced to 0 (both stages), clr ignored (no restart).
- rst asserted mid-clear: FSM to IDLE, counter to 0, array contents unspecified; sequence restarts from 0 after release if CLEAR_ON_RESET=1.
- Reset values: dout_a=0, dout_b=0, all output pipeline registers 0, counter 0, FSM IDLE, busy=0 during reset. Array not reset.
- DATA_WIDTH not a multiple of BYTE_WIDTH is an elaboration error.

## Timing
- Read latency: 1 cycle (OUT_REG=0), 2 cycles (OUT_REG=1) from addr sampled to dout valid.
- Write visible to a read issued the next cycle on either port regardless of RDW_MODE.
- Clear duration: busy rises the cycle after the trigger edge, stays high exactly 2**ADDR_WIDTH cycles, falls; user ops accepted on the first edge with busy=0.
- busy is registered; no combinational path from clr or rst-release to busy within the trigger cycle.
- Pipeline stages keep advancing during clear (carrying 0), so the first valid read after clear appears at normal latency.

## Test plan
- ADDR_WIDTH=4, CLEAR_VALUE=8'hA5, release rst -> busy high 16 cycles; then reads of addresses 0..15 return 8'hA5 one cycle after addr.
- DATA_WIDTH=16: write 16'h1234 to addr 3, then we_a=2'b10 din_a=16'hFF00 -> next read of addr 3 returns 16'hFF34.
- Port A writes 8'h55 to addr 7 while port B reads addr 7 same cycle -> dout_b = old value (RDW_MODE=0) or 8'h55 (RDW_MODE=1).
- Both ports write addr 2 same cycle, A=8'h11 B=8'h22 full enables -> subsequent read returns 8'h11; with we_a=0 on a 16-bit lane split, B lane data lands.
- OUT_REG=1: read addr 5 holding 8'h3C -> dout valid exactly 2 cycles after addr presented; back-to-back reads stream one per cycle.
- clr pulse, assert rst at clear cycle 5 -> busy=0 and douts 0 immediately; after release, busy high full 2**ADDR_WIDTH cycles and all words equal CLEAR_VALUE; writes issued while busy have no effect.
